// File: rtl/phosphor_pkg.sv
// Shared pixel-word layout and FSM encoding for the phosphor ring buffer
// and the tap reader.
package phosphor_pkg;

  localparam int WORD_W = 32;
  localparam int LUMA_W = 12;
  localparam int X_W    = 10;
  localparam int Y_W    = 10;
  localparam int TAP_N  = 8;
  localparam int IDX_W  = 3;
  localparam int SNAP_W = WORD_W * TAP_N;

  localparam int LUMA_LSB = 0;
  localparam int X_LSB    = 12;
  localparam int Y_LSB    = 22;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_EMIT = 2'd2
  } state_e;

  // Field order matches the bit positions above, msb first.
  typedef struct packed {
    logic [Y_W-1:0]    y;
    logic [X_W-1:0]    x;
    logic [LUMA_W-1:0] luma;
  } pixel_t;

  function automatic pixel_t unpack_word(logic [WORD_W-1:0] w);
    return pixel_t'(w);
  endfunction

endpackage

// File: rtl/phosphor_decay_calc.sv
// Splits a pixel word and applies per-tap decay (luma >> tap index);
// emit is high when the decayed luma reaches the threshold.
module phosphor_decay_calc
  import phosphor_pkg::*;
#(
  parameter logic [LUMA_W-1:0] LUMA_MIN = 12'd1
) (
  input  logic [WORD_W-1:0] word,
  input  logic [IDX_W-1:0]  idx,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic [LUMA_W-1:0] luma,
  output logic              emit
);

  pixel_t px;

  assign px   = unpack_word(word);
  assign x    = px.x;
  assign y    = px.y;
  assign luma = px.luma >> idx;
  assign emit = (luma >= LUMA_MIN);

endmodule

// File: rtl/phosphor_tap_reader.sv
// Snapshots eight ring-buffer taps and walks them oldest-last, offering
// each sufficiently bright decayed pixel over a valid/ready handshake.
module phosphor_tap_reader
  import phosphor_pkg::*;
#(
  parameter logic [LUMA_W-1:0] LUMA_MIN = 12'd1,
  parameter int                DROP_W   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [SNAP_W-1:0] taps,
  input  logic              taps_valid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [X_W-1:0]    out_x,
  output logic [Y_W-1:0]    out_y,
  output logic [LUMA_W-1:0] out_luma,
  output logic              busy,
  output logic [DROP_W-1:0] drop_count
);

  state_e              state;
  state_e              state_nx;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    idx_nx;
  logic [SNAP_W-1:0]   snap;
  logic                load;
  logic [WORD_W-1:0]   word;
  logic [X_W-1:0]      calc_x;
  logic [Y_W-1:0]      calc_y;
  logic [LUMA_W-1:0]   calc_luma;
  logic                calc_emit;
  logic                last;
  logic                drop;

  assign word = snap[idx*WORD_W +: WORD_W];
  assign last = (idx == IDX_W'(TAP_N - 1));
  assign drop = taps_valid && (state != ST_IDLE);

  phosphor_decay_calc #(
    .LUMA_MIN(LUMA_MIN)
  ) u_calc (
    .word(word),
    .idx (idx),
    .x   (calc_x),
    .y   (calc_y),
    .luma(calc_luma),
    .emit(calc_emit)
  );

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    load     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (taps_valid) begin
          state_nx = ST_SCAN;
          idx_nx   = '0;
          load     = 1'b1;
        end
      end
      ST_SCAN: begin
        if (calc_emit) begin
          state_nx = ST_EMIT;
        end else if (last) begin
          state_nx = ST_IDLE;
        end else begin
          idx_nx = idx + 1'b1;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          if (last) begin
            state_nx = ST_IDLE;
          end else begin
            state_nx = ST_SCAN;
            idx_nx   = idx + 1'b1;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      snap       <= '0;
      out_valid  <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      out_luma   <= '0;
      busy       <= 1'b0;
      drop_count <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      busy  <= (state_nx != ST_IDLE);
      if (load) begin
        snap <= taps;
      end
      // Output registers only load from SCAN, so they hold through EMIT.
      if (state == ST_SCAN && calc_emit) begin
        out_valid <= 1'b1;
        out_x     <= calc_x;
        out_y     <= calc_y;
        out_luma  <= calc_luma;
      end else if (state == ST_EMIT && out_ready) begin
        out_valid <= 1'b0;
      end
      if (drop && drop_count != {DROP_W{1'b1}}) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

endmodule
